// File: rtl/video_in_pkg.sv
// rtl/video_in_pkg.sv - shared types for the video input capture DMA
package video_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_FLUSH
  } state_e;

  // Word index is sized for the largest supported frame (640x480 pixels);
  // smaller frames simply leave the upper index bits at zero.
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned IDX_W      = $clog2(DEF_WIDTH * DEF_HEIGHT / 4);
  localparam int unsigned ENTRY_W    = IDX_W + 32;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } fifo_entry_t;

  // Byte address of a frame word, wrapping at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
    return base + (32'(idx) << 2);
  endfunction

endpackage

// File: rtl/video_in_fifo.sv
// rtl/video_in_fifo.sv - first-word-fall-through word FIFO for the capture DMA
module video_in_fifo
  import video_in_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               more_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign more_o  = (count_q > (AW+1)'(1));

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop is accepted.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/video_in_wb_writer.sv
// rtl/video_in_wb_writer.sv - packs 8-bit pixels into words and writes frames over Wishbone
module video_in_wb_writer
  import video_in_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic [31:0] cfg_base_addr,
  input  logic        cfg_start,
  input  logic        px_valid,
  input  logic [7:0]  px_data,
  input  logic        px_sof,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_DAT_I,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        bus_err
);

  localparam int unsigned PW       = IDX_W + 2;
  localparam logic [PW-1:0] LAST_PIX = PW'(WIDTH * HEIGHT - 1);

  state_e      state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [23:0] pack_q, pack_d;
  logic [31:0] base_q, base_d;
  logic        overflow_q, overflow_d;
  logic        bus_err_q, bus_err_d;
  logic        done_q, done_d;
  logic        stb_q, stb_d;
  logic        take_px, push, pop, push_ok;
  logic        fifo_full, fifo_empty, fifo_more;
  fifo_entry_t push_e, head_e;
  logic        unused_in;

  // Read data and the low address bits have no use in a write-only master.
  assign unused_in = ^{p_wb_DAT_I, cfg_base_addr[1:0]};

  // The word index is simply the pixel count divided by four, so dropped words still advance it.
  assign push_e.idx  = pix_cnt_q[PW-1:2];
  assign push_e.data = {px_data, pack_q};

  assign pop     = stb_q && (p_wb_ACK_I || p_wb_ERR_I);
  assign push_ok = push && (!fifo_full || pop);

  video_in_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (p_clk),
    .rst_ni (p_resetn),
    .push_i (push),
    .wdata_i(push_e),
    .pop_i  (pop),
    .rdata_o(head_e),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .more_o (fifo_more)
  );

  // Capture FSM, pixel packer and sticky status next-state.
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    pack_d     = pack_q;
    base_d     = base_q;
    overflow_d = overflow_q;
    bus_err_d  = bus_err_q;
    done_d     = 1'b0;
    take_px    = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          base_d     = {cfg_base_addr[31:2], 2'b00};
          pix_cnt_d  = '0;
          overflow_d = 1'b0;
          bus_err_d  = 1'b0;
          state_d    = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        if (px_valid && px_sof) begin
          take_px = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (px_valid) begin
          take_px = 1'b1;
          if (pix_cnt_q == LAST_PIX) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty && !stb_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take_px) begin
      pix_cnt_d = pix_cnt_q + PW'(1);
      case (pix_cnt_q[1:0])
        2'd0:    pack_d[7:0]   = px_data;
        2'd1:    pack_d[15:8]  = px_data;
        2'd2:    pack_d[23:16] = px_data;
        default: push          = 1'b1;
      endcase
    end
    if (push && !push_ok) overflow_d = 1'b1;
    if (stb_q && p_wb_ERR_I) bus_err_d = 1'b1;
  end

  // Write engine strobe: retry drops STB for one cycle, ACK/ERR continue only if a word remains.
  always_comb begin
    stb_d = 1'b0;
    if (!stb_q)                           stb_d = !fifo_empty;
    else if (p_wb_ACK_I || p_wb_ERR_I)    stb_d = fifo_more || push_ok;
    else if (p_wb_RTY_I)                  stb_d = 1'b0;
    else                                  stb_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q    <= ST_IDLE;
      pix_cnt_q  <= '0;
      pack_q     <= '0;
      base_q     <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
      done_q     <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      pack_q     <= pack_d;
      base_q     <= base_d;
      overflow_q <= overflow_d;
      bus_err_q  <= bus_err_d;
      done_q     <= done_d;
      stb_q      <= stb_d;
    end
  end

  // Bus outputs are forced to zero outside a cycle so reset and idle look identical.
  assign p_wb_CYC_O = stb_q;
  assign p_wb_STB_O = stb_q;
  assign p_wb_WE_O  = stb_q;
  assign p_wb_SEL_O = {4{stb_q}};
  assign p_wb_ADR_O = stb_q ? word_addr(base_q, head_e.idx) : 32'h0;
  assign p_wb_DAT_O = stb_q ? head_e.data : 32'h0;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign overflow   = overflow_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_video_in_wb_writer.sv
// tb/tb_video_in_wb_writer.sv - scoreboard bench for video_in_wb_writer
module tb_video_in_wb_writer;

  logic        p_clk = 1'b0;
  logic        p_resetn = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        px_valid = 1'b0, px_sof = 1'b0;
  logic [7:0]  px_data = '0;
  logic [31:0] dat_i = '0;
  logic        ack_en = 1'b1, rty_armed = 1'b0, err_armed = 1'b0;
  logic [31:0] rty_adr = '0, err_adr = '0;
  logic        sel24 = 1'b0;

  logic [31:0] adr_a, dat_a, adr_b, dat_b;
  logic [3:0]  sel_a, sel_b;
  logic cyc_a, stb_a, we_a, ack_a, err_a, rty_a, busy_a, done_a, ovf_a, berr_a;
  logic cyc_b, stb_b, we_b, ack_b, err_b, rty_b, busy_b, done_b, ovf_b, berr_b;

  assign rty_a = stb_a & rty_armed & (adr_a == rty_adr);
  assign err_a = stb_a & err_armed & (adr_a == err_adr) & ~rty_a;
  assign ack_a = stb_a & ack_en & ~rty_a & ~err_a;
  assign rty_b = stb_b & rty_armed & (adr_b == rty_adr);
  assign err_b = stb_b & err_armed & (adr_b == err_adr) & ~rty_b;
  assign ack_b = stb_b & ack_en & ~rty_b & ~err_b;

  video_in_wb_writer #(.WIDTH(8), .HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .p_clk(p_clk), .p_resetn(p_resetn), .cfg_base_addr(cfg_base_addr), .cfg_start(start_a),
    .px_valid(px_valid), .px_data(px_data), .px_sof(px_sof),
    .p_wb_ADR_O(adr_a), .p_wb_DAT_O(dat_a), .p_wb_DAT_I(dat_i), .p_wb_SEL_O(sel_a),
    .p_wb_CYC_O(cyc_a), .p_wb_STB_O(stb_a), .p_wb_WE_O(we_a),
    .p_wb_ACK_I(ack_a), .p_wb_ERR_I(err_a), .p_wb_RTY_I(rty_a),
    .busy(busy_a), .frame_done(done_a), .overflow(ovf_a), .bus_err(berr_a)
  );

  video_in_wb_writer #(.WIDTH(8), .HEIGHT(3), .FIFO_DEPTH(4)) dut24 (
    .p_clk(p_clk), .p_resetn(p_resetn), .cfg_base_addr(cfg_base_addr), .cfg_start(start_b),
    .px_valid(px_valid), .px_data(px_data), .px_sof(px_sof),
    .p_wb_ADR_O(adr_b), .p_wb_DAT_O(dat_b), .p_wb_DAT_I(dat_i), .p_wb_SEL_O(sel_b),
    .p_wb_CYC_O(cyc_b), .p_wb_STB_O(stb_b), .p_wb_WE_O(we_b),
    .p_wb_ACK_I(ack_b), .p_wb_ERR_I(err_b), .p_wb_RTY_I(rty_b),
    .busy(busy_b), .frame_done(done_b), .overflow(ovf_b), .bus_err(berr_b)
  );

  wire [31:0] m_adr  = sel24 ? adr_b  : adr_a;
  wire [31:0] m_dat  = sel24 ? dat_b  : dat_a;
  wire [3:0]  m_sel  = sel24 ? sel_b  : sel_a;
  wire        m_cyc  = sel24 ? cyc_b  : cyc_a;
  wire        m_stb  = sel24 ? stb_b  : stb_a;
  wire        m_we   = sel24 ? we_b   : we_a;
  wire        m_ack  = sel24 ? ack_b  : ack_a;
  wire        m_err  = sel24 ? err_b  : err_a;
  wire        m_rty  = sel24 ? rty_b  : rty_a;
  wire        m_done = sel24 ? done_b : done_a;
  wire        m_busy = sel24 ? busy_b : busy_a;

  always #5 p_clk = ~p_clk;

  int checks = 0, errors = 0;
  int ack_cnt = 0, err_cnt = 0, rty_hits = 0, rty_phase = 0;
  logic [31:0] rty_adr_seen, rty_dat_seen;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus monitor: every terminated cycle pops the scoreboard; retries are tracked separately.
  always @(negedge p_clk) begin
    if (p_resetn) begin
      if (rty_phase == 1) begin
        chk("rty_drop", m_stb, 0);
        rty_armed = 1'b0;
        rty_phase = 2;
      end else if (rty_phase == 2 && m_stb) begin
        chk("rty_adr", m_adr, rty_adr_seen);
        chk("rty_dat", m_dat, rty_dat_seen);
        rty_phase = 0;
      end
      if (m_stb) begin
        chk("wr_ctl", {m_sel, m_we, m_cyc}, 6'h3F);
        if (m_rty) begin
          rty_hits++;
          rty_adr_seen = m_adr;
          rty_dat_seen = m_dat;
          rty_phase = 1;
        end else if (m_ack || m_err) begin
          if (m_ack) ack_cnt++; else err_cnt++;
          if (exp_q.size() == 0) begin
            chk("sb_under", exp_q.size(), 1);
          end else begin
            mon_e = exp_q.pop_front();
            chk("wr_adr", m_adr, mon_e[63:32]);
            chk("wr_dat", m_dat, mon_e[31:0]);
          end
        end
      end
    end
  end

  task automatic start(input bit b, input logic [31:0] base);
    cfg_base_addr = base;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge p_clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] d, input logic s);
    px_valid = 1'b1;
    px_data  = d;
    px_sof   = s;
    @(negedge p_clk);
    px_valid = 1'b0;
    px_sof   = 1'b0;
  endtask

  // Pixel i carries value i; the 4th pixel of each word queues the expected write unless dropped.
  task automatic send_range(input int first, input int last, input logic [31:0] base, input int drop);
    for (int i = first; i <= last; i++) begin
      if (i % 4 == 3 && i / 4 != drop)
        exp_q.push_back({base + 32'(4 * (i / 4)), 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
      send_px(8'(i), i == 0);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!m_done && n < budget) begin
      @(negedge p_clk);
      n++;
    end
    chk({tag, "_done_seen"}, n < budget, 1);
    chk({tag, "_busy_low"}, m_busy, 0);
    @(negedge p_clk);
    chk({tag, "_done_pulse"}, m_done, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge p_clk);
    chk("rst_bus_a", {adr_a, dat_a} != 64'h0, 0);
    chk("rst_ctl_a", {sel_a, cyc_a, stb_a, we_a}, 0);
    chk("rst_stat_a", {busy_a, done_a, ovf_a, berr_a}, 0);
    chk("rst_stat_b", {stb_b, busy_b, done_b, ovf_b, berr_b}, 0);
    p_resetn = 1'b1;
    @(negedge p_clk);

    // Normal frame, unaligned base
    ack_cnt = 0;
    start(0, 32'h1000_0002);
    chk("busy_start", busy_a, 1);
    send_range(0, 15, 32'h1000_0000, -1);
    wait_done("normal", 200);
    chk("normal_acks", ack_cnt, 4);
    chk("normal_status", {ovf_a, berr_a}, 0);

    // Junk before SOF must be discarded
    ack_cnt = 0;
    start(0, 32'h1000_0002);
    for (int j = 0; j < 5; j++) send_px(8'hA0 + 8'(j), 1'b0);
    send_range(0, 15, 32'h1000_0000, -1);
    wait_done("junk", 200);
    chk("junk_acks", ack_cnt, 4);

    // Stalled bus on the 24-pixel variant: word 4 overflows
    sel24 = 1'b1;
    ack_en = 1'b0;
    ack_cnt = 0;
    start(1, 32'h2000_0000);
    send_range(0, 19, 32'h2000_0000, 4);
    chk("stall_ovf", ovf_b, 1);
    chk("stall_stb", stb_b, 1);
    chk("stall_noack", ack_cnt, 0);
    ack_en = 1'b1;
    send_range(20, 23, 32'h2000_0000, 4);
    wait_done("stall", 200);
    chk("stall_acks", ack_cnt, 5);
    chk("stall_ovf_sticky", ovf_b, 1);

    ack_cnt = 0;
    start(1, 32'h2000_0100);
    chk("ovf_clr", ovf_b, 0);
    send_range(0, 23, 32'h2000_0100, -1);
    wait_done("full24", 200);
    chk("full24_acks", ack_cnt, 6);
    chk("full24_ovf", ovf_b, 0);
    sel24 = 1'b0;

    // Retry once on word 1
    ack_cnt = 0;
    rty_hits = 0;
    rty_adr = 32'h3000_0004;
    rty_armed = 1'b1;
    start(0, 32'h3000_0000);
    send_range(0, 15, 32'h3000_0000, -1);
    wait_done("rty", 200);
    chk("rty_acks", ack_cnt, 4);
    chk("rty_hits", rty_hits, 1);
    chk("rty_phase_done", rty_phase, 0);
    chk("rty_berr", berr_a, 0);
    rty_armed = 1'b0;

    // Error on word 2
    ack_cnt = 0;
    err_cnt = 0;
    err_adr = 32'h4000_0008;
    err_armed = 1'b1;
    start(0, 32'h4000_0000);
    send_range(0, 15, 32'h4000_0000, -1);
    wait_done("err", 200);
    chk("err_acks", ack_cnt, 3);
    chk("err_cnt", err_cnt, 1);
    chk("err_berr", berr_a, 1);
    err_armed = 1'b0;

    // Restart clears bus_err; then asynchronous reset mid-capture with STB high
    ack_en = 1'b0;
    start(0, 32'h5000_0000);
    chk("berr_clr", berr_a, 0);
    send_range(0, 7, 32'h5000_0000, -1);
    chk("pre_rst_stb", stb_a, 1);
    #2 p_resetn = 1'b0;
    #1;
    chk("arst_bus", {adr_a, dat_a} != 64'h0, 0);
    chk("arst_ctl", {sel_a, cyc_a, stb_a, we_a}, 0);
    chk("arst_stat", {busy_a, done_a, ovf_a, berr_a}, 0);
    exp_q.delete();
    @(negedge p_clk);
    p_resetn = 1'b1;
    ack_en = 1'b1;
    @(negedge p_clk);
    ack_cnt = 0;
    start(0, 32'h6000_0000);
    send_range(0, 15, 32'h6000_0000, -1);
    wait_done("post_rst", 200);
    chk("post_rst_acks", ack_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
